rv_controller: RTL
==================

# rv_controller

Sequencing controller for the revaluate stage of the encoder. On a `start` request it steps the revaluate datapath through every slice of the state: load the operand register, capture the result register, write back. It then reports completion with a done/ack handshake. It owns the load strobes of the stage's registers and the slice index that addresses the state memory.

## Interface
Parameters:
- `SLICES`, 64: number of slices processed per run (≥1)
- `CNT_W`, 6: width of slice index; must satisfy 2^CNT_W ≥ SLICES

Ports:
- `clk`  input  1  clock; all state changes on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `start`  input  1  run request; sampled only in IDLE
- `ack`  input  1  consumer acknowledge of `done`; sampled only in DONE
- `ready`  output  1  high in IDLE; controller accepts `start`
- `ld_in`  output  1  load strobe for operand register (`ld` of the input register)
- `ld_res`  output  1  load strobe for result register
- `mem_we`  output  1  write enable for state memory at `slice_idx`
- `slice_idx`  output  CNT_W  current slice address
- `done`  output  1  run complete; held until `ack`

## Operation
- FSM states: IDLE, LOAD, CALC, WRITE, DONE. All outputs are Moore, decoded from state and counter only; no combinational input-to-output path.
- IDLE: `ready`=1.
  - `start`=1 → LOAD, `slice_idx` cleared to 0.
  - Otherwise stay in IDLE.
- LOAD: `ld_in`=1 → CALC.
- CALC: `ld_res`=1 → WRITE.
- WRITE: `mem_we`=1.
  - If `slice_idx`==SLICES-1 → DONE, `slice_idx` holds its value.
  - Else `slice_idx` increments by 1 → LOAD.
- DONE: `done`=1.
  - `ack`=1 → IDLE.
  - Otherwise hold DONE indefinitely.
- Exactly one of `ready`, `ld_in`, `ld_res`, `mem_we`, `done` is high in every cycle.
- `slice_idx` changes only on the IDLE→LOAD clear and the WRITE→LOAD increment. It is never observed above SLICES-1, so there is no wrap-around.
- `start` outside IDLE is ignored, not queued. `ack` outside DONE is ignored.
- `start` and `ack` both high in DONE: `ack` wins → IDLE. A fresh `start` is required in IDLE.
- SLICES=1: single LOAD/CALC/WRITE pass, then DONE.

## Timing
- Reset values, valid from the cycle after `rst` is sampled high: state IDLE, `slice_idx`=0, `ready`=1, `ld_in`=`ld_res`=`mem_we`=`done`=0.
- Reset is synchronous, so outputs reflect the pre-reset state during the cycle `rst` is first asserted.
- Reset mid-run (any state) aborts the run without completing the pending write. It never raises `done`.
- `rst` has priority over `start` and `ack` in the same cycle.
- Let edge 0 be the edge that samples `start`. Then:
  - LOAD occupies cycle 1.
  - Slice k uses cycles 3k+1 (LOAD), 3k+2 (CALC), 3k+3 (WRITE).
  - DONE is first high in cycle 3·SLICES+1.
- `ack` sampled on the first DONE edge → `ready` high in cycle 3·SLICES+2. Minimum start-to-start period is 3·SLICES+2 cycles.
- Datapath contract:
  - Operand register is valid in CALC.
  - Result register is valid in WRITE.
  - Memory write occurs on the edge that ends WRITE, addressed by `slice_idx` of that cycle.

## Test plan
- Reset then idle, no stimulus: `ready`=1, all strobes 0, `slice_idx`=0 for 10 cycles.
- SLICES=4, `start` pulse one cycle, `ack` tied 1:
  - Strobe sequence `ld_in`,`ld_res`,`mem_we` repeats 4 times.
  - `slice_idx` is 0,1,2,3 across the passes.
  - `done` high exactly in cycle 13.
  - `ready` high again in cycle 14.
- SLICES=4, `ack` held 0 for 20 cycles after `done`: `done` and `slice_idx`=3 held stable. `ack`=1 → `ready`=1 next cycle.
- `start` held high continuously, `ack` tied 1 (SLICES=4): back-to-back runs, second LOAD in cycle 15, `slice_idx` cleared to 0 at restart. `start` during runs is ignored.
- `rst` asserted in CALC of slice 2 (SLICES=4): next cycle IDLE, `slice_idx`=0, `mem_we` never asserted for slice 2, `done` never asserted.
- SLICES=1: `start` → LOAD, CALC, WRITE in cycles 1–3, `done` in cycle 4, `slice_idx` constant 0. `start`+`ack` together in DONE → IDLE with no new run.

Source files
------------

// File: rtl/rv_controller_if.sv
// rv_controller_if: start/ack handshake, datapath strobes and slice address of the revaluate stage
interface rv_controller_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic             ack;
  logic             ready;
  logic             ld_in;
  logic             ld_res;
  logic             mem_we;
  logic             done;
  logic [CNT_W-1:0] slice_idx;
  modport master (
    input  start, ack,
    output ready, ld_in, ld_res, mem_we, done, slice_idx
  );
  modport slave (
    output start, ack,
    input  ready, ld_in, ld_res, mem_we, done, slice_idx
  );
endinterface

// File: rtl/rv_controller.sv
// rv_controller: steps the revaluate datapath through LOAD/CALC/WRITE for every slice, then done/ack
module rv_controller #(
  parameter int SLICES = 64,
  parameter int CNT_W  = 6
) (
  input logic             clk,
  input logic             rst,
  rv_controller_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             ready_q, ld_in_q, ld_res_q, mem_we_q, done_q;
  logic             last;
  assign last = idx_q == LAST;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        state_d = bus.start ? LOAD : IDLE;
        idx_d   = bus.start ? '0 : idx_q;
      end
      LOAD:  state_d = CALC;
      CALC:  state_d = WRITE;
      WRITE: begin
        state_d = last ? DONE : LOAD;
        idx_d   = last ? idx_q : idx_q + CNT_W'(1);
      end
      DONE:    state_d = bus.ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      ld_in_q  <= 1'b0;
      ld_res_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ready_q  <= state_d == IDLE;
      ld_in_q  <= state_d == LOAD;
      ld_res_q <= state_d == CALC;
      mem_we_q <= state_d == WRITE;
      done_q   <= state_d == DONE;
    end
  end
  assign bus.ready     = ready_q;
  assign bus.ld_in     = ld_in_q;
  assign bus.ld_res    = ld_res_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.done      = done_q;
  assign bus.slice_idx = idx_q;
endmodule
